// File: rtl/hazard_sequencer.sv
// Pipeline control sequencer: load-use bubbles, control-flow hold and redirect,
// and saturating stall/redirect performance counters.
module hazard_sequencer #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CW       = 16
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ID_VALID,
  input  logic [6:0]    ID_OP,
  input  logic [4:0]    ID_RS1,
  input  logic [4:0]    ID_RS2,
  input  logic          EX_VALID,
  input  logic [6:0]    EX_OP,
  input  logic [4:0]    EX_RD,
  input  logic          B_TAKEN,
  output logic [1:0]    PC_SEL,
  output logic          IFID_HOLD,
  output logic          IFID_FLUSH,
  output logic          IDEX_BUBBLE,
  output logic [CW-1:0] STALL_CNT,
  output logic [CW-1:0] REDIR_CNT
);

  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;

  localparam logic [1:0] PcInc4 = 2'b00;
  localparam logic [1:0] PcHold = 2'b01;
  localparam logic [1:0] PcJump = 2'b10;

  localparam logic [CW-1:0] CntMax = {CW{1'b1}};

  typedef enum logic [1:0] {StRun, StLoadStall, StCtrlWait, StRedirect} state_e;

  state_e     state_q, state_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic       rs1_used, rs2_used, load_use, id_ctrl, ex_jump;

  assign rs1_used = !(ID_OP inside {OpJal, OpLui, OpAuipc});
  assign rs2_used = ID_OP inside {OpBranch, OpStore, OpOp};
  assign load_use = ID_VALID && EX_VALID && (EX_OP == OpLoad) && (EX_RD != 5'd0) &&
                    ((rs1_used && (ID_RS1 == EX_RD)) || (rs2_used && (ID_RS2 == EX_RD)));
  assign id_ctrl  = ID_OP inside {OpJal, OpJalr, OpBranch};
  assign ex_jump  = EX_VALID && ((EX_OP inside {OpJal, OpJalr}) ||
                                 ((EX_OP == OpBranch) && B_TAKEN));

  always_comb begin
    PC_SEL      = PcInc4;
    IFID_HOLD   = 1'b0;
    IFID_FLUSH  = 1'b0;
    IDEX_BUBBLE = 1'b0;
    state_d     = state_q;
    bcnt_d      = bcnt_q;
    unique case (state_q)
      StRun: begin
        if (load_use) begin
          PC_SEL      = PcHold;
          IFID_HOLD   = 1'b1;
          IDEX_BUBBLE = 1'b1;
          if (LOAD_LAT > 1) begin
            bcnt_d  = 3'(LOAD_LAT - 1);
            state_d = StLoadStall;
          end
        end else if (ID_VALID && id_ctrl) begin
          PC_SEL  = PcHold;
          state_d = StCtrlWait;
        end
      end
      StLoadStall: begin
        PC_SEL      = PcHold;
        IFID_HOLD   = 1'b1;
        IDEX_BUBBLE = 1'b1;
        bcnt_d      = bcnt_q - 3'd1;
        if (bcnt_q == 3'd1) state_d = StRun;
      end
      StCtrlWait: begin
        // The slot fetched behind the control instruction is always squashed.
        IFID_FLUSH = 1'b1;
        if (ex_jump) begin
          PC_SEL  = PcJump;
          state_d = StRedirect;
        end else begin
          state_d = StRun;
        end
      end
      StRedirect: begin
        IFID_FLUSH = 1'b1;
        state_d    = StRun;
      end
      default: state_d = StRun;
    endcase
    if (RESET) begin
      PC_SEL      = PcInc4;
      IFID_HOLD   = 1'b0;
      IFID_FLUSH  = 1'b1;
      IDEX_BUBBLE = 1'b0;
      state_d     = StRun;
      bcnt_d      = 3'd0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StRun;
      bcnt_q    <= 3'd0;
      STALL_CNT <= '0;
      REDIR_CNT <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      if ((PC_SEL == PcHold) && (STALL_CNT != CntMax)) STALL_CNT <= STALL_CNT + CW'(1);
      if ((PC_SEL == PcJump) && (REDIR_CNT != CntMax)) REDIR_CNT <= REDIR_CNT + CW'(1);
    end
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control sequencer that drives the program counter's next-address select and the IF/ID and ID/EX pipeline register controls.
- Detects control-flow instructions in decode and holds fetch until the branch or jump resolves in execute, then issues a redirect.
- Detects load-use hazards and inserts LOAD_LAT bubbles.
- Keeps saturating performance counters for stall cycles and redirects.

Parameters:
- LOAD_LAT, 1, number of bubble cycles inserted per load-use hazard (1..7).
- CW, 16, width of each performance counter.

Ports:
- CLK  input  1  clock.
- RESET  input  1  synchronous, active-high reset.
- ID_VALID  input  1  decode stage holds a real instruction.
- ID_OP  input  7  opcode of the instruction in decode.
- ID_RS1  input  5  rs1 field of the instruction in decode.
- ID_RS2  input  5  rs2 field of the instruction in decode.
- EX_VALID  input  1  execute stage holds a real instruction.
- EX_OP  input  7  opcode of the instruction in execute.
- EX_RD  input  5  rd field of the instruction in execute.
- B_TAKEN  input  1  branch condition result from execute; meaningful only when EX_OP is BRANCH.
- PC_SEL  output  2  next-PC select: 00 INC4 (PC+4), 01 HOLD, 10 JUMP (PC+offset). 11 is never driven.
- IFID_HOLD  output  1  IF/ID register keeps its value.
- IFID_FLUSH  output  1  IF/ID register loads a NOP (valid=0).
- IDEX_BUBBLE  output  1  ID/EX register loads a NOP.
- STALL_CNT  output  CW  count of cycles with PC_SEL=HOLD.
- REDIR_CNT  output  CW  count of cycles with PC_SEL=JUMP.

Behaviour:
- Opcodes: JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011.
  - CTRL = JAL, JALR or BRANCH.
- rs1 is used by every opcode except JAL, LUI (0110111) and AUIPC (0010111).
- rs2 is used only by BRANCH, STORE (0100011) and OP (0110011).
- Load-use hazard (LU), evaluated combinationally. All of the following must hold:
  - ID_VALID & EX_VALID.
  - EX_OP = LOAD.
  - EX_RD != 0.
  - EX_RD matches a used rs field of the decode instruction.
- States: RUN, LOAD_STALL, CTRL_WAIT, REDIRECT. There is a 3-bit bubble counter bcnt.
- Outputs are combinational from state and inputs. State and counters are registered.
- RUN:
  - If LU: PC_SEL=HOLD, IFID_HOLD=1, IDEX_BUBBLE=1.
    - If LOAD_LAT>1: bcnt<=LOAD_LAT-1, go to LOAD_STALL.
    - Otherwise stay in RUN.
  - Else if ID_VALID & ID_OP in CTRL: PC_SEL=HOLD, go to CTRL_WAIT. The CTRL instruction advances to EX normally.
  - Else: PC_SEL=INC4, all other outputs 0.
  - LU has priority over CTRL. A CTRL instruction waiting on a load is stalled first and recognised once LU clears.
- LOAD_STALL:
  - PC_SEL=HOLD, IFID_HOLD=1, IDEX_BUBBLE=1, bcnt decrements each cycle.
  - When bcnt=1, return to RUN the next cycle.
  - LU is not re-evaluated in this state.
- CTRL_WAIT (the CTRL instruction is now in EX):
  - IFID_FLUSH=1 in every case, to squash the slot fetched behind the CTRL instruction.
  - If EX_VALID and (EX_OP in {JAL,JALR} or (EX_OP=BRANCH and B_TAKEN)): PC_SEL=JUMP, go to REDIRECT.
  - Else: PC_SEL=INC4, go to RUN.
  - If EX_VALID=0 (defensive case), treat as not taken.
- REDIRECT:
  - PC_SEL=INC4, IFID_FLUSH=1, go to RUN. This squashes the instruction fetched at the pre-jump address.
- Counters:
  - STALL_CNT increments in every cycle with PC_SEL=HOLD.
  - REDIR_CNT increments in every cycle with PC_SEL=JUMP.
  - Both saturate at 2^CW-1 and never wrap.
- Reset:
  - RESET sampled high returns the FSM to RUN and clears bcnt, STALL_CNT and REDIR_CNT, taking effect at the next edge. This applies from any state, including mid-stall and mid-redirect.
  - While RESET is high, outputs are forced: PC_SEL=INC4, IFID_FLUSH=1, IFID_HOLD=0, IDEX_BUBBLE=0.
- Output invariants:
  - IFID_HOLD and IFID_FLUSH are never both 1.
  - IDEX_BUBBLE implies PC_SEL=HOLD.

Test Plan:
- Reset then straight-line code (ID_OP=0110011, no LU), 10 cycles → PC_SEL=00 on every cycle, all other controls 0, both counters 0.
- LOAD in EX with EX_RD=5, ID OP with ID_RS2=5, LOAD_LAT=1 → exactly one cycle of PC_SEL=01, IFID_HOLD=1, IDEX_BUBBLE=1. Repeat with LOAD_LAT=3 → three such cycles, then RUN, STALL_CNT=3. Repeat with EX_RD=0, or rs2 matching under ID_OP=0010011 → no stall.
- BRANCH in ID, then B_TAKEN=1 in the next cycle → PC_SEL sequence 01,10,00, IFID_FLUSH high on cycles 2 and 3, REDIR_CNT=1. Repeat with B_TAKEN=0 → 01,00, one flush cycle, REDIR_CNT=0.
- JALR in ID while LOAD in EX with EX_RD=ID_RS1 → load-use bubble first, then CTRL_WAIT, then REDIRECT.
- Assert RESET in CTRL_WAIT and in LOAD_STALL (LOAD_LAT=4) → next cycle state is RUN, counters 0, PC_SEL=00.
- CW=4 with 20 stalls → STALL_CNT holds at 15.
